// File: rtl/piece_move_fsm.sv
// Piece-movement controller: erases, collision-checks and redraws the active
// PIECE_DIM x PIECE_DIM piece bitmap on the board for spawn/down/left/right commands.
module piece_move_fsm #(
    parameter int PIECE_DIM = 4,
    parameter int BOARD_W   = 10,
    parameter int BOARD_H   = 20,
    parameter int XW        = 4,
    parameter int YW        = 5,
    parameter int COLOR_W   = 3,
    parameter int SPAWN_X   = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         Resetn,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd,
    output logic                         cmd_ready,
    output logic [$clog2(PIECE_DIM)-1:0] XB,
    output logic [$clog2(PIECE_DIM)-1:0] YB,
    input  logic [COLOR_W-1:0]           cell_color,
    output logic [XW-1:0]                bx,
    output logic [YW-1:0]                by,
    input  logic                         board_occ,
    output logic                         board_we,
    output logic [COLOR_W-1:0]           board_wdata,
    output logic [XW-1:0]                piece_x,
    output logic [YW-1:0]                piece_y,
    output logic                         done,
    output logic                         moved,
    output logic                         locked,
    output logic                         game_over
);
    localparam int                CW   = $clog2(PIECE_DIM);
    localparam logic [CW-1:0]     LAST = CW'(PIECE_DIM - 1);
    localparam logic signed [XW:0] BW  = (XW+1)'(BOARD_W);
    localparam logic signed [YW:0] BH  = (YW+1)'(BOARD_H);
    localparam logic signed [XW:0] SX  = (XW+1)'(SPAWN_X);

    localparam logic [1:0] CMD_DOWN  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_SPAWN = 2'b11;

    typedef enum logic [2:0] {IDLE, ERASE, CHECK, COMMIT, DRAW, FIN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cx, cy;
    logic signed [XW:0] pos_x, tgt_x, base_x, ax, dx;
    logic signed [YW:0] pos_y, tgt_y, base_y, ay, dy;
    logic               spawn_r, down_r, coll_r, moved_r, locked_r, over_r;
    logic               accept, last_cell, walking, occupied, in_range, cell_hit;

    assign cmd_ready = (state == IDLE) && !over_r;
    assign accept    = cmd_valid && cmd_ready;
    assign last_cell = (cx == LAST) && (cy == LAST);
    assign walking   = (state == ERASE) || (state == CHECK) || (state == DRAW);

    always_comb begin
        dx = '0;
        dy = '0;
        case (cmd)
            CMD_LEFT:  dx = '1;
            CMD_RIGHT: dx = (XW+1)'(1);
            CMD_DOWN:  dy = (YW+1)'(1);
            default:   ;
        endcase
    end

    // Positions are kept signed one bit wider so a piece whose empty left
    // column hangs off the board edge still addresses correctly.
    assign base_x = (state == CHECK) ? tgt_x : pos_x;
    assign base_y = (state == CHECK) ? tgt_y : pos_y;
    assign ax     = base_x + $signed({{(XW+1-CW){1'b0}}, cx});
    assign ay     = base_y + $signed({{(YW+1-CW){1'b0}}, cy});

    assign in_range = !ax[XW] && (ax < BW) && !ay[YW] && (ay < BH);
    assign occupied = |cell_color;
    assign cell_hit = occupied && (!in_range || board_occ);

    assign XB          = cx;
    assign YB          = cy;
    assign bx          = ax[XW-1:0];
    assign by          = ay[YW-1:0];
    assign board_we    = ((state == ERASE) || (state == DRAW)) && occupied && in_range;
    assign board_wdata = ((state == DRAW) && board_we) ? cell_color : '0;
    assign piece_x     = pos_x[XW-1:0];
    assign piece_y     = pos_y[YW-1:0];
    assign done        = (state == FIN);
    assign moved       = moved_r;
    assign locked      = locked_r;
    assign game_over   = over_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (cmd == CMD_SPAWN) ? CHECK : ERASE;
            ERASE:   if (last_cell) state_nxt = CHECK;
            CHECK:   if (last_cell) state_nxt = COMMIT;
            COMMIT:  state_nxt = (coll_r && spawn_r) ? FIN : DRAW;
            DRAW:    if (last_cell) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Raster walk over the bitmap: XB inner, YB outer, wraps to (0,0) after each pass.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (walking) begin
            if (cx == LAST) begin
                cx <= '0;
                cy <= (cy == LAST) ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            pos_x    <= '0;
            pos_y    <= '0;
            tgt_x    <= '0;
            tgt_y    <= '0;
            spawn_r  <= 1'b0;
            down_r   <= 1'b0;
            coll_r   <= 1'b0;
            moved_r  <= 1'b0;
            locked_r <= 1'b0;
            over_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // The target origin stands in for the latched dx/dy.
                    spawn_r  <= (cmd == CMD_SPAWN);
                    down_r   <= (cmd == CMD_DOWN);
                    tgt_x    <= (cmd == CMD_SPAWN) ? SX : pos_x + dx;
                    tgt_y    <= (cmd == CMD_SPAWN) ? '0 : pos_y + dy;
                    coll_r   <= 1'b0;
                    moved_r  <= 1'b0;
                    locked_r <= 1'b0;
                end
                CHECK: coll_r <= coll_r | cell_hit;
                COMMIT: begin
                    if (!coll_r) begin
                        pos_x   <= tgt_x;
                        pos_y   <= tgt_y;
                        moved_r <= 1'b1;
                    end else if (spawn_r) begin
                        over_r <= 1'b1;
                    end else if (down_r) begin
                        locked_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_piece_move_fsm.sv
// Directed bench for piece_move_fsm: O-piece ROM and board memory models,
// a table of command vectors plus hand sequences for game-over and mid-command reset.
module tb_piece_move_fsm;
    localparam logic [1:0] C_DOWN = 2'b00, C_LEFT = 2'b01, C_RIGHT = 2'b10, C_SPAWN = 2'b11;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic [1:0] XB, YB;
    logic [2:0] cell_color;
    logic [3:0] bx;
    logic [4:0] by;
    logic       board_occ;
    logic       board_we;
    logic [2:0] board_wdata;
    logic [3:0] piece_x;
    logic [4:0] piece_y;
    logic       done, moved, locked, game_over;

    piece_move_fsm dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .XB(XB), .YB(YB), .cell_color(cell_color),
        .bx(bx), .by(by), .board_occ(board_occ), .board_we(board_we),
        .board_wdata(board_wdata), .piece_x(piece_x), .piece_y(piece_y),
        .done(done), .moved(moved), .locked(locked), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // O-piece, colour 5, occupying bitmap cells (1..2, 1..2)
    assign cell_color = ((XB == 2'd1 || XB == 2'd2) && (YB == 2'd1 || YB == 2'd2)) ? 3'd5 : 3'd0;

    logic [2:0] board [0:19][0:9];
    int         wr_cnt = 0;
    int         oob_cnt = 0;
    logic       clr_board = 1'b0;
    logic       pre_en = 1'b0;
    int         pre_x = 0, pre_y = 0;

    always_comb begin
        board_occ = 1'b0;
        if (bx < 4'd10 && by < 5'd20) board_occ = (board[by][bx] != 3'd0);
    end

    always @(posedge CLOCK_50) begin
        if (clr_board)
            for (int y = 0; y < 20; y++)
                for (int x = 0; x < 10; x++) board[y][x] <= 3'd0;
        if (pre_en) board[pre_y][pre_x] <= 3'd2;
        if (board_we) begin
            wr_cnt <= wr_cnt + 1;
            if (bx < 4'd10 && by < 5'd20) board[by][bx] <= board_wdata;
            else oob_cnt <= oob_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic int img_err(input int px, input int py);
        int e = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                logic [2:0] want;
                want = (x - px >= 1 && x - px <= 2 && y - py >= 1 && y - py <= 2) ? 3'd5 : 3'd0;
                if (board[y][x] !== want) e++;
            end
        return e;
    endfunction

    typedef struct {
        logic [1:0] c;
        int         lat;
        int         mv;
        int         lk;
        int         px;
        int         py;
        int         nwr;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [1:0] c, input int lat, input int mv, input int lk,
                                input int px, input int py, input int nwr);
        vec_t v;
        v.c = c; v.lat = lat; v.mv = mv; v.lk = lk; v.px = px; v.py = py; v.nwr = nwr;
        vecs.push_back(v);
    endfunction

    // cmd_valid is held through the whole busy period and dropped as done is seen.
    task automatic run_cmd(input logic [1:0] c, output int lat, output int nwr,
                           output logic mv, output logic lk, output logic go,
                           output logic [3:0] px, output logic [4:0] py);
        int w0;
        @(negedge CLOCK_50);
        cmd = c;
        cmd_valid = 1'b1;
        w0 = wr_cnt;
        lat = -1;
        @(posedge CLOCK_50);
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLOCK_50);
            if (done) begin
                lat = k;
                break;
            end
        end
        cmd_valid = 1'b0;
        nwr = wr_cnt - w0;
        mv = moved;
        lk = locked;
        go = game_over;
        px = piece_x;
        py = piece_y;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        cmd_valid = 1'b0;
        clr_board = 1'b1;
        @(negedge CLOCK_50);
        clr_board = 1'b0;
        Resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000");
        $fatal(1);
    end

    initial begin
        int lat, nwr, w0, dones;
        logic mv, lk, go;
        logic [3:0] px;
        logic [4:0] py;

        add(C_SPAWN, 34, 1, 0,  3, 0, 4);
        add(C_LEFT,  50, 1, 0,  2, 0, 8);
        add(C_LEFT,  50, 1, 0,  1, 0, 8);
        add(C_LEFT,  50, 1, 0,  0, 0, 8);
        add(C_LEFT,  50, 1, 0, -1, 0, 8);   // left cell now on column 0
        add(C_LEFT,  50, 0, 0, -1, 0, 8);   // blocked by left wall, redraw in place
        add(C_RIGHT, 50, 1, 0,  0, 0, 8);
        add(C_RIGHT, 50, 1, 0,  1, 0, 8);
        for (int i = 1; i <= 17; i++) add(C_DOWN, 50, 1, 0, 1, i, 8);
        add(C_DOWN,  50, 0, 1,  1, 17, 8);  // bottom cell on row 19: locks

        // reset state
        clr_board = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        clr_board = 1'b0;
        chk("rst_done", 32'(done), 0);
        chk("rst_moved", 32'(moved), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_board_we", 32'(board_we), 0);
        chk("rst_wdata", 32'(board_wdata), 0);
        chk("rst_xb_yb", 32'({XB, YB}), 0);
        chk("rst_piece", 32'({piece_x, piece_y}), 0);
        Resetn = 1'b1;
        @(negedge CLOCK_50);
        chk("rst_ready", 32'(cmd_ready), 1);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].c, lat, nwr, mv, lk, go, px, py);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_moved", i), 32'(mv), vecs[i].mv);
            chk($sformatf("v%0d_locked", i), 32'(lk), vecs[i].lk);
            chk($sformatf("v%0d_piece_x", i), 32'(px), vecs[i].px & 15);
            chk($sformatf("v%0d_piece_y", i), 32'(py), vecs[i].py);
            chk($sformatf("v%0d_writes", i), nwr, vecs[i].nwr);
            chk($sformatf("v%0d_board_bad_cells", i), img_err(vecs[i].px, vecs[i].py), 0);
            w0 = wr_cnt;
            repeat (2) @(negedge CLOCK_50);
            chk($sformatf("v%0d_idle_after", i), 32'({done, cmd_ready, board_we}), 32'(3'b010));
            chk($sformatf("v%0d_no_extra_writes", i), wr_cnt - w0, 0);
        end

        // spawn onto an occupied cell
        do_reset();
        @(negedge CLOCK_50);
        pre_en = 1'b1; pre_x = 4; pre_y = 1;
        @(negedge CLOCK_50);
        pre_en = 1'b0;
        run_cmd(C_SPAWN, lat, nwr, mv, lk, go, px, py);
        chk("go_latency", lat, 18);
        chk("go_game_over", 32'(go), 1);
        chk("go_moved", 32'(mv), 0);
        chk("go_locked", 32'(lk), 0);
        chk("go_writes", nwr, 0);
        chk("go_piece", 32'({px, py}), 0);
        w0 = wr_cnt;
        dones = 0;
        cmd = C_DOWN;
        cmd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK_50);
            if (cmd_ready) dones += 100;
            if (done) dones++;
        end
        cmd_valid = 1'b0;
        chk("go_blocked_ready_done", dones, 0);
        chk("go_blocked_writes", wr_cnt - w0, 0);
        chk("go_sticky", 32'(game_over), 1);

        // reset in the middle of a down command
        do_reset();
        chk("mr_game_over_cleared", 32'(game_over), 0);
        run_cmd(C_SPAWN, lat, nwr, mv, lk, go, px, py);
        chk("mr_spawn_latency", lat, 34);
        @(negedge CLOCK_50);
        cmd = C_DOWN;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50);
        repeat (20) @(negedge CLOCK_50);
        Resetn = 1'b0;
        #1;
        chk("mr_board_we", 32'(board_we), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_moved_locked", 32'({moved, locked}), 0);
        chk("mr_piece", 32'({piece_x, piece_y}), 0);
        chk("mr_xb_yb", 32'({XB, YB}), 0);
        chk("mr_wdata", 32'(board_wdata), 0);
        cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        @(negedge CLOCK_50);
        chk("mr_ready_after", 32'(cmd_ready), 1);
        chk("mr_idle_after", 32'({done, board_we}), 0);

        chk("out_of_range_writes", oob_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
